dsi_lane_tx: RTL and testbench

Parametrised successor lane transmitter for the DSI controller. It takes byte packets on a valid/ready stream and buffers them in a FIFO of configurable depth. It then runs the LP-11 → LP-01 → LP-00 → HS-0 → SYNC → DATA → TRAIL → LP-11 sequence with run-time programmable timing, supports multi-packet HS bursts, and flags underruns. It drives a parallel byte to the external serializer and the LP line drivers; it sits between the packet assembler and the lane PHY buffers.

---
 rtl/dsi_lane_pkg.sv | 24 ++
 rtl/dsi_lane_tx_if.sv | 12 +
 rtl/dsi_lane_fifo.sv | 67 ++++++
 rtl/dsi_lane_tx.sv | 191 +++++++++++++++++++
 tb/tb_dsi_lane_tx.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dsi_lane_pkg.sv
// Shared definitions for the DSI lane transmitter: FSM states, LP line codes
// and the default HS leader byte.
package dsi_lane_pkg;

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_LPX   = 3'd1,
    ST_PREP  = 3'd2,
    ST_ZERO  = 3'd3,
    ST_SYNC  = 3'd4,
    ST_DATA  = 3'd5,
    ST_TRAIL = 3'd6,
    ST_EXIT  = 3'd7
  } state_e;

  // LP line state packed as {lp_p, lp_n}
  typedef logic [1:0] lp_t;
  localparam lp_t LP11 = 2'b11;
  localparam lp_t LP01 = 2'b01;
  localparam lp_t LP00 = 2'b00;

  localparam logic [7:0] SYNC_DEFAULT = 8'b00011101;

endpackage

// File: rtl/dsi_lane_tx_if.sv
// Byte stream from the packet assembler into the lane transmitter.
interface dsi_lane_tx_if;

  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);

endinterface

// File: rtl/dsi_lane_fifo.sv
// Synchronous FIFO of {last, data} entries with occupancy and a count of
// complete packets (entries carrying the last flag).
module dsi_lane_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [8:0]    wr_entry,
  input  logic          rd_en,
  output logic [8:0]    head,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] count,
  output logic [PW-1:0] pkt_cnt
);

  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d, pkt_q, pkt_d;
  logic          wr_fire, rd_fire;

  assign full    = (count_q == PW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rptr_q];
  assign count   = count_q;
  assign pkt_cnt = pkt_q;

  // full gates the write even when a pop happens in the same cycle
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_fire) begin
      mem_d[wptr_q] = wr_entry;
      wptr_d        = wptr_q + 1'b1;
    end
    if (rd_fire) begin
      rptr_d = rptr_q + 1'b1;
    end
    count_d = count_q + PW'(wr_fire) - PW'(rd_fire);
    pkt_d   = pkt_q + PW'(wr_fire && wr_entry[8]) - PW'(rd_fire && head[8]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      pkt_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      pkt_q   <= pkt_d;
    end
  end

endmodule

// File: rtl/dsi_lane_tx.sv
// DSI data lane transmitter: buffers byte packets and sequences the
// LP-11/LP-01/LP-00/HS-0/SYNC/DATA/TRAIL/LP-11 lane protocol.
module dsi_lane_tx
  import dsi_lane_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_W        = 8,
  parameter logic [7:0]  SYNC_PATTERN = SYNC_DEFAULT
) (
  input  logic             clk_base,
  input  logic             reset,
  input  logic [CNT_W-1:0] cfg_t_lpx,
  input  logic [CNT_W-1:0] cfg_t_prep,
  input  logic [CNT_W-1:0] cfg_t_zero,
  input  logic [CNT_W-1:0] cfg_t_trail,
  input  logic [CNT_W-1:0] cfg_t_exit,
  input  logic             cfg_burst_en,
  dsi_lane_tx_if.slave     s,
  output logic             active,
  output logic             underrun,
  output logic [7:0]       hs_data,
  output logic             hs_oe,
  output logic             lp_p,
  output logic             lp_n,
  output logic             lp_oe
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH + 1);

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] t_lpx_q, t_lpx_d, t_prep_q, t_prep_d, t_zero_q, t_zero_d;
  logic [CNT_W-1:0] t_trail_q, t_trail_d, t_exit_q, t_exit_d;
  logic             burst_q, burst_d;
  logic             cur_last_q, cur_last_d, cur_more_q, cur_more_d, cur_ur_q, cur_ur_d;
  logic             last_b_q, last_b_d;
  logic             active_q, active_d, underrun_q, underrun_d, hs_oe_q, hs_oe_d, lp_oe_q, lp_oe_d;
  logic [7:0]       hs_data_q, hs_data_d;
  lp_t              lp_q, lp_d;

  logic             pop;
  logic [8:0]       fifo_head;
  logic             fifo_full, fifo_empty;
  logic [PW-1:0]    fifo_count, fifo_pkt;

  dsi_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk_base),
    .rst      (reset),
    .wr_en    (s.s_valid),
    .wr_entry ({s.s_last, s.s_data}),
    .rd_en    (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .pkt_cnt  (fifo_pkt)
  );

  assign s.s_ready = !fifo_full;

  // Outputs are registered from next_state, so the byte shown in a DATA
  // cycle is popped on the edge that enters it; its last/burst decision is
  // held in cur_* and consumed by the following evaluation.
  always_comb begin
    state_d    = state_q;
    t_lpx_d    = t_lpx_q;
    t_prep_d   = t_prep_q;
    t_zero_d   = t_zero_q;
    t_trail_d  = t_trail_q;
    t_exit_d   = t_exit_q;
    burst_d    = burst_q;
    cur_last_d = cur_last_q;
    cur_more_d = cur_more_q;
    cur_ur_d   = cur_ur_q;
    last_b_d   = last_b_q;
    pop        = 1'b0;

    case (state_q)
      ST_STOP: if (fifo_pkt != '0 || fifo_count == PW'(FIFO_DEPTH)) begin
        state_d   = ST_LPX;
        t_lpx_d   = at_least_one(cfg_t_lpx);
        t_prep_d  = at_least_one(cfg_t_prep);
        t_zero_d  = at_least_one(cfg_t_zero);
        t_trail_d = at_least_one(cfg_t_trail);
        t_exit_d  = at_least_one(cfg_t_exit);
        burst_d   = cfg_burst_en;
      end
      ST_LPX:   if (cnt_q == t_lpx_q - 1'b1)   state_d = ST_PREP;
      ST_PREP:  if (cnt_q == t_prep_q - 1'b1)  state_d = ST_ZERO;
      ST_ZERO:  if (cnt_q == t_zero_q - 1'b1)  state_d = ST_SYNC;
      ST_SYNC:  state_d = ST_DATA;
      ST_DATA:  if (cur_ur_q || (cur_last_q && !cur_more_q)) state_d = ST_TRAIL;
      ST_TRAIL: if (cnt_q == t_trail_q - 1'b1) state_d = ST_EXIT;
      ST_EXIT:  if (cnt_q == t_exit_q - 1'b1)  state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    active_d   = (state_d != ST_STOP);
    underrun_d = 1'b0;
    hs_data_d  = '0;
    hs_oe_d    = 1'b0;
    lp_oe_d    = 1'b1;
    lp_d       = LP11;

    case (state_d)
      ST_LPX:  lp_d = LP01;
      ST_PREP: lp_d = LP00;
      ST_ZERO, ST_SYNC, ST_DATA, ST_TRAIL: begin
        hs_oe_d = 1'b1;
        lp_oe_d = 1'b0;
        lp_d    = LP00;
        if (state_d == ST_SYNC) begin
          hs_data_d = SYNC_PATTERN;
        end else if (state_d == ST_TRAIL) begin
          hs_data_d = {8{~last_b_q}};
        end else if (state_d == ST_DATA) begin
          if (fifo_empty) begin
            underrun_d = 1'b1;
            hs_data_d  = {8{~last_b_q}};
            cur_ur_d   = 1'b1;
          end else begin
            pop        = 1'b1;
            hs_data_d  = fifo_head[7:0];
            last_b_d   = fifo_head[7];
            cur_last_d = fifo_head[8];
            cur_more_d = burst_q && (fifo_pkt > PW'(fifo_head[8]));
            cur_ur_d   = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      state_q    <= ST_STOP;
      cnt_q      <= '0;
      t_lpx_q    <= CNT_W'(1);
      t_prep_q   <= CNT_W'(1);
      t_zero_q   <= CNT_W'(1);
      t_trail_q  <= CNT_W'(1);
      t_exit_q   <= CNT_W'(1);
      burst_q    <= 1'b0;
      cur_last_q <= 1'b0;
      cur_more_q <= 1'b0;
      cur_ur_q   <= 1'b0;
      last_b_q   <= 1'b0;
      active_q   <= 1'b0;
      underrun_q <= 1'b0;
      hs_data_q  <= '0;
      hs_oe_q    <= 1'b0;
      lp_oe_q    <= 1'b1;
      lp_q       <= LP11;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      t_lpx_q    <= t_lpx_d;
      t_prep_q   <= t_prep_d;
      t_zero_q   <= t_zero_d;
      t_trail_q  <= t_trail_d;
      t_exit_q   <= t_exit_d;
      burst_q    <= burst_d;
      cur_last_q <= cur_last_d;
      cur_more_q <= cur_more_d;
      cur_ur_q   <= cur_ur_d;
      last_b_q   <= last_b_d;
      active_q   <= active_d;
      underrun_q <= underrun_d;
      hs_data_q  <= hs_data_d;
      hs_oe_q    <= hs_oe_d;
      lp_oe_q    <= lp_oe_d;
      lp_q       <= lp_d;
    end
  end

  assign active   = active_q;
  assign underrun = underrun_q;
  assign hs_data  = hs_data_q;
  assign hs_oe    = hs_oe_q;
  assign lp_oe    = lp_oe_q;
  assign lp_p     = lp_q[1];
  assign lp_n     = lp_q[0];

endmodule

// File: tb/tb_dsi_lane_tx.sv
// Directed bench for dsi_lane_tx: cycle-exact lane traces for single packet,
// burst, underrun, backpressure and mid-burst reset.
module tb_dsi_lane_tx;

  logic       clk_base = 1'b0;
  logic       reset;
  logic [7:0] cfg_t_lpx, cfg_t_prep, cfg_t_zero, cfg_t_trail, cfg_t_exit;
  logic       cfg_burst_en;
  logic       active, underrun, hs_oe, lp_p, lp_n, lp_oe;
  logic [7:0] hs_data;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  dsi_lane_tx_if s_if ();

  dsi_lane_tx #(
    .FIFO_DEPTH   (4),
    .CNT_W        (8),
    .SYNC_PATTERN (8'b00011101)
  ) dut (
    .clk_base     (clk_base),
    .reset        (reset),
    .cfg_t_lpx    (cfg_t_lpx),
    .cfg_t_prep   (cfg_t_prep),
    .cfg_t_zero   (cfg_t_zero),
    .cfg_t_trail  (cfg_t_trail),
    .cfg_t_exit   (cfg_t_exit),
    .cfg_burst_en (cfg_burst_en),
    .s            (s_if.slave),
    .active       (active),
    .underrun     (underrun),
    .hs_data      (hs_data),
    .hs_oe        (hs_oe),
    .lp_p         (lp_p),
    .lp_n         (lp_n),
    .lp_oe        (lp_oe)
  );

  always #5 clk_base = ~clk_base;

  // lane status word: {active, underrun, hs_oe, lp_oe, lp_p, lp_n, hs_data}
  function automatic logic [13:0] st(input logic a, input logic u, input logic hoe,
                                     input logic loe, input logic [1:0] lp, input logic [7:0] d);
    return {a, u, hoe, loe, lp, d};
  endfunction

  function automatic logic [13:0] status();
    return {active, underrun, hs_oe, lp_oe, lp_p, lp_n, hs_data};
  endfunction

  localparam logic [13:0] W_STOP = {1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 8'h00};
  localparam logic [13:0] W_LPX  = {1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 8'h00};
  localparam logic [13:0] W_PREP = {1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00};
  localparam logic [13:0] W_EXIT = {1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 8'h00};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_expect(input string tag, input logic [13:0] exp, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      chk(tag, {2'b00, status()}, {2'b00, exp});
      @(negedge clk_base);
    end
  endtask

  task automatic preamble(input int unsigned n_lpx);
    run_expect("lpx",  W_LPX,  n_lpx);
    run_expect("prep", W_PREP, 3);
    run_expect("zero", st(1, 0, 1, 0, 2'b00, 8'h00), 4);
    run_expect("sync", st(1, 0, 1, 0, 2'b00, 8'h1D), 1);
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    s_if.s_last  = l;
    @(negedge clk_base);
  endtask

  task automatic set_cfg(input logic [7:0] lpx, input logic burst);
    cfg_t_lpx    = lpx;
    cfg_t_prep   = 8'd3;
    cfg_t_zero   = 8'd4;
    cfg_t_trail  = 8'd2;
    cfg_t_exit   = 8'd3;
    cfg_burst_en = burst;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    s_if.s_valid = 1'b0;
    s_if.s_data  = 8'h00;
    s_if.s_last  = 1'b0;
    set_cfg(8'd2, 1'b0);

    // 1: reset values held stable
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_base);
      chk("reset_status", {2'b00, status()}, {2'b00, W_STOP});
      chk("reset_ready", {15'd0, s_if.s_ready}, 16'd1);
    end
    reset = 1'b0;
    @(negedge clk_base);

    // 2: single packet
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h83, 1'b1);
    s_if.s_valid = 1'b0;
    chk("single_wait", {2'b00, status()}, {2'b00, W_STOP});
    @(negedge clk_base);
    preamble(2);
    run_expect("single_d0", st(1, 0, 1, 0, 2'b00, 8'h11), 1);
    run_expect("single_d1", st(1, 0, 1, 0, 2'b00, 8'h22), 1);
    run_expect("single_d2", st(1, 0, 1, 0, 2'b00, 8'h83), 1);
    run_expect("single_trail", st(1, 0, 1, 0, 2'b00, 8'h00), 2);
    run_expect("single_exit", W_EXIT, 3);
    run_expect("single_stop", W_STOP, 2);

    // 3a: two packets in one HS burst
    set_cfg(8'd2, 1'b1);
    push(8'h05, 1'b1);
    push(8'h06, 1'b1);
    s_if.s_valid = 1'b0;
    preamble(2);
    run_expect("burst_d0", st(1, 0, 1, 0, 2'b00, 8'h05), 1);
    run_expect("burst_d1", st(1, 0, 1, 0, 2'b00, 8'h06), 1);
    run_expect("burst_trail", st(1, 0, 1, 0, 2'b00, 8'hFF), 2);
    run_expect("burst_exit", W_EXIT, 3);
    run_expect("burst_stop", W_STOP, 2);

    // 3b: same packets without burst -> two full sequences
    set_cfg(8'd2, 1'b0);
    push(8'h05, 1'b1);
    push(8'h06, 1'b1);
    s_if.s_valid = 1'b0;
    preamble(2);
    run_expect("nb1_data", st(1, 0, 1, 0, 2'b00, 8'h05), 1);
    run_expect("nb1_trail", st(1, 0, 1, 0, 2'b00, 8'hFF), 2);
    run_expect("nb1_exit", W_EXIT, 3);
    run_expect("nb_gap_stop", W_STOP, 1);
    preamble(2);
    run_expect("nb2_data", st(1, 0, 1, 0, 2'b00, 8'h06), 1);
    run_expect("nb2_trail", st(1, 0, 1, 0, 2'b00, 8'hFF), 2);
    run_expect("nb2_exit", W_EXIT, 3);
    run_expect("nb2_stop", W_STOP, 2);

    // 4: underrun after full-start without a last byte
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    push(8'h04, 1'b0);
    s_if.s_valid = 1'b0;
    chk("ur_full_ready", {15'd0, s_if.s_ready}, 16'd0);
    chk("ur_full_stop", {2'b00, status()}, {2'b00, W_STOP});
    @(negedge clk_base);
    preamble(2);
    run_expect("ur_d0", st(1, 0, 1, 0, 2'b00, 8'h01), 1);
    run_expect("ur_d1", st(1, 0, 1, 0, 2'b00, 8'h02), 1);
    run_expect("ur_d2", st(1, 0, 1, 0, 2'b00, 8'h03), 1);
    run_expect("ur_d3", st(1, 0, 1, 0, 2'b00, 8'h04), 1);
    run_expect("ur_pulse", st(1, 1, 1, 0, 2'b00, 8'hFF), 1);
    run_expect("ur_trail", st(1, 0, 1, 0, 2'b00, 8'hFF), 2);
    run_expect("ur_exit", W_EXIT, 3);
    run_expect("ur_stop", W_STOP, 2);

    // 5: backpressure with s_valid held, and cfg_t_lpx=0 behaving as 1
    set_cfg(8'd0, 1'b0);
    push(8'h10, 1'b0);
    push(8'h20, 1'b0);
    push(8'h30, 1'b0);
    push(8'h40, 1'b0);
    s_if.s_data = 8'h50;
    s_if.s_last = 1'b1;
    chk("bp_ready_full", {15'd0, s_if.s_ready}, 16'd0);
    @(negedge clk_base);
    chk("bp_ready_lpx", {15'd0, s_if.s_ready}, 16'd0);
    run_expect("bp_lpx0", W_LPX, 1);
    run_expect("bp_prep", W_PREP, 3);
    run_expect("bp_zero", st(1, 0, 1, 0, 2'b00, 8'h00), 4);
    chk("bp_ready_sync", {15'd0, s_if.s_ready}, 16'd0);
    run_expect("bp_sync", st(1, 0, 1, 0, 2'b00, 8'h1D), 1);
    chk("bp_ready_after_pop", {15'd0, s_if.s_ready}, 16'd1);
    run_expect("bp_d0", st(1, 0, 1, 0, 2'b00, 8'h10), 1);
    s_if.s_valid = 1'b0;
    run_expect("bp_d1", st(1, 0, 1, 0, 2'b00, 8'h20), 1);
    run_expect("bp_d2", st(1, 0, 1, 0, 2'b00, 8'h30), 1);
    run_expect("bp_d3", st(1, 0, 1, 0, 2'b00, 8'h40), 1);
    run_expect("bp_d4", st(1, 0, 1, 0, 2'b00, 8'h50), 1);
    run_expect("bp_trail", st(1, 0, 1, 0, 2'b00, 8'hFF), 2);
    run_expect("bp_exit", W_EXIT, 3);
    run_expect("bp_stop", W_STOP, 2);

    // 6: asynchronous reset while byte 2 is on the lane
    set_cfg(8'd2, 1'b0);
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h83, 1'b1);
    s_if.s_valid = 1'b0;
    @(negedge clk_base);
    preamble(2);
    run_expect("rst_d0", st(1, 0, 1, 0, 2'b00, 8'h11), 1);
    chk("rst_d1", {2'b00, status()}, {2'b00, st(1, 0, 1, 0, 2'b00, 8'h22)});
    reset = 1'b1;
    #1;
    chk("rst_async_status", {2'b00, status()}, {2'b00, W_STOP});
    @(negedge clk_base);
    reset = 1'b0;
    @(negedge clk_base);
    chk("rst_after_ready", {15'd0, s_if.s_ready}, 16'd1);
    run_expect("rst_fifo_discarded", W_STOP, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
